// File: rtl/tx_mux_pkg.sv
// tx_mux_pkg: shared definitions for the TX framing path.
//  - FSM state encodings (plain 3-bit constants so legacy users can compare them)
//  - clog2_min1: width helper that never returns 0 (a 1-entry index still needs 1 bit)
//  - bytes_of: payload bytes per word
//  - hdr_byte: header byte for a granted channel index
package tx_mux_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GRANT = 3'd1;
  localparam logic [2:0] ST_HDR   = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_REL   = 3'd5;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  function automatic int bytes_of(input int dw);
    return dw / 8;
  endfunction

  // Channel index zero-extended; callers pass at most 8 index bits (N_CH <= 256).
  function automatic logic [7:0] hdr_byte(input logic [7:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/tx_arb.sv
// tx_arb: combinational request arbiter.
//  ARB_RR=0 : lowest set request index wins.
//  ARB_RR=1 : first set index strictly after ptr, wrapping (ptr = last winner).
// Ports:
//  req   in  N_CH   request vector
//  ptr   in  IDX_W  last granted index (round-robin only)
//  grant out N_CH   one-hot winner (0 when no request)
//  gidx  out IDX_W  winner index
//  any   out 1      at least one request present
module tx_arb #(
  parameter int N_CH   = 4,
  parameter int ARB_RR = 0,
  parameter int IDX_W  = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [IDX_W-1:0] gidx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    // Scan order starts just after ptr for round-robin; first hit wins.
    for (int i = 0; i < N_CH; i++) begin
      j = (ARB_RR != 0) ? ((int'(ptr) + 1 + i) % N_CH) : i;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        gidx     = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tx_mux_arb.sv
// tx_mux_arb: arbitrates N_CH word producers and serialises the granted word
// into the 8-bit TX FIFO as [header = channel index][data bytes MSB first]
// [checksum, optional]. Every byte waits on FIFO backpressure.
// Optional feature: define TX_MUX_ARB_CSUM_EN to append an XOR checksum byte
// (header ^ all data bytes) after the data; undefined builds have no checksum
// logic at all.
// Ports:
//  clk    in   system clock
//  rst    in   synchronous reset, active high (abandons any partial frame)
//  req    in   N_CH level requests
//  data   in   N_CH*DATA_W words, channel i at data[i*DATA_W +: DATA_W]
//  wfull  in   TX FIFO full
//  out    out  byte to FIFO (0 outside byte states)
//  winc   out  FIFO write strobe (= !wfull in byte states)
//  accept out  one-hot grant, GRANT through REL
//  busy   out  state != IDLE
module tx_mux_arb
  import tx_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int ARB_RR = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH*DATA_W-1:0]   data,
  input  logic                     wfull,
  output logic [7:0]               out,
  output logic                     winc,
  output logic [N_CH-1:0]          accept,
  output logic                     busy
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = clog2_min1(N_CH);
  localparam int K_W   = clog2_min1(BYTES);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  g_q, g_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [N_CH-1:0]   accept_q, accept_d;
`ifdef TX_MUX_ARB_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic [N_CH-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  tx_arb #(.N_CH(N_CH), .ARB_RR(ARB_RR), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .gidx  (arb_idx),
    .any   (arb_any)
  );

  assign accept = accept_q;
  assign busy   = (state_q != ST_IDLE);

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    ptr_d    = ptr_q;
    word_d   = word_q;
    k_d      = k_q;
    accept_d = accept_q;
`ifdef TX_MUX_ARB_CSUM_EN
    csum_d   = csum_q;
`endif
    out      = 8'h00;
    winc     = 1'b0;
    case (state_q)
      ST_IDLE: if (arb_any) begin
        state_d  = ST_GRANT;
        g_d      = arb_idx;
        ptr_d    = arb_idx;
        accept_d = arb_grant;
      end
      ST_GRANT: begin
        word_d  = data[int'(g_q)*DATA_W +: DATA_W];
        k_d     = '0;
        state_d = ST_HDR;
      end
      ST_HDR: begin
        out  = hdr_byte(8'(g_q));
        winc = !wfull;
        if (!wfull) begin
          state_d = ST_DATA;
`ifdef TX_MUX_ARB_CSUM_EN
          csum_d  = hdr_byte(8'(g_q));
`endif
        end
      end
      ST_DATA: begin
        // Word is shifted left per written byte, so the MSB byte is always current.
        out  = word_q[DATA_W-1 -: 8];
        winc = !wfull;
        if (!wfull) begin
          word_d = word_q << 8;
          k_d    = k_q + K_W'(1);
`ifdef TX_MUX_ARB_CSUM_EN
          csum_d = csum_q ^ word_q[DATA_W-1 -: 8];
          if (k_q == K_W'(BYTES-1)) state_d = ST_CSUM;
`else
          if (k_q == K_W'(BYTES-1)) state_d = ST_REL;
`endif
        end
      end
`ifdef TX_MUX_ARB_CSUM_EN
      ST_CSUM: begin
        out  = csum_q;
        winc = !wfull;
        if (!wfull) state_d = ST_REL;
      end
`endif
      ST_REL: if (!req[g_q]) begin
        state_d  = ST_IDLE;
        accept_d = '0;
      end
      default: begin
        state_d  = ST_IDLE;
        accept_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      g_q      <= '0;
      ptr_q    <= IDX_W'(N_CH-1);  // ch0 wins the first round-robin pass
      word_q   <= '0;
      k_q      <= '0;
      accept_q <= '0;
`ifdef TX_MUX_ARB_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      k_q      <= k_d;
      accept_q <= accept_d;
`ifdef TX_MUX_ARB_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_mux_arb.sv
module tb_tx_mux_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]   req0 = '0, req1 = '0;
  logic [7:0]   req2 = '0;
  logic [63:0]  data = '0;
  logic [255:0] data2 = '0;
  logic         wfull = 1'b0;

  logic [7:0] out0, out1, out2;
  logic       winc0, winc1, winc2, busy0, busy1, busy2;
  logic [3:0] acc0, acc1;
  logic [7:0] acc2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp0[$], exp1[$], exp2[$];

  tx_mux_arb #(.N_CH(4), .DATA_W(16), .ARB_RR(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .data(data), .wfull(wfull),
    .out(out0), .winc(winc0), .accept(acc0), .busy(busy0));
  tx_mux_arb #(.N_CH(4), .DATA_W(16), .ARB_RR(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .data(data), .wfull(wfull),
    .out(out1), .winc(winc1), .accept(acc1), .busy(busy1));
  tx_mux_arb #(.N_CH(8), .DATA_W(32), .ARB_RR(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .data(data2), .wfull(wfull),
    .out(out2), .winc(winc2), .accept(acc2), .busy(busy2));

  // Scoreboard monitors: every FIFO write pops one expected byte.
  always @(negedge clk) if (!rst && winc0) begin
    logic [7:0] e;
    total++;
    if (wfull) begin bad++; $display("FAIL d0_write_while_full out=%h", out0); end
    else if (exp0.size() == 0) begin bad++; $display("FAIL d0_extra_byte got=%h want=none", out0); end
    else begin
      e = exp0.pop_front();
      if (out0 !== e) begin bad++; $display("FAIL d0_byte got=%h want=%h", out0, e); end
    end
  end
  always @(negedge clk) if (!rst && winc1) begin
    logic [7:0] e;
    total++;
    if (wfull) begin bad++; $display("FAIL d1_write_while_full out=%h", out1); end
    else if (exp1.size() == 0) begin bad++; $display("FAIL d1_extra_byte got=%h want=none", out1); end
    else begin
      e = exp1.pop_front();
      if (out1 !== e) begin bad++; $display("FAIL d1_byte got=%h want=%h", out1, e); end
    end
  end
  always @(negedge clk) if (!rst && winc2) begin
    logic [7:0] e;
    total++;
    if (wfull) begin bad++; $display("FAIL d2_write_while_full out=%h", out2); end
    else if (exp2.size() == 0) begin bad++; $display("FAIL d2_extra_byte got=%h want=none", out2); end
    else begin
      e = exp2.pop_front();
      if (out2 !== e) begin bad++; $display("FAIL d2_byte got=%h want=%h", out2, e); end
    end
  end

  function automatic int qsize(input int which);
    case (which)
      0: return exp0.size();
      1: return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic qpush(input int which, input logic [7:0] b);
    case (which)
      0: exp0.push_back(b);
      1: exp1.push_back(b);
      default: exp2.push_back(b);
    endcase
  endtask

  // Expected frame: header, data bytes MSB first, optional XOR checksum.
  task automatic push_frame(input int which, input logic [7:0] hdr,
                            input logic [31:0] w, input int nbytes);
    logic [7:0] b, cs;
    qpush(which, hdr);
    cs = hdr;
    for (int i = 0; i < nbytes; i++) begin
      b  = w[8*(nbytes-1-i) +: 8];
      cs = cs ^ b;
      qpush(which, b);
    end
`ifdef TX_MUX_ARB_CSUM_EN
    qpush(which, cs);
`endif
  endtask

  // Returns at the posedge after the queue has shrunk to 'target'.
  task automatic wait_until(input int which, input int target, input int limit);
    int n;
    n = 0;
    while (qsize(which) > target && n < limit) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (qsize(which) > target) begin
      bad++;
      $display("FAIL wait_q%0d left=%0d want=%0d", which, qsize(which), target);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy0, winc0, acc0, out0} !== 14'b0) begin
      bad++; $display("FAIL reset_d0 got=%b want=0", {busy0, winc0, acc0, out0});
    end
    total++;
    if ({busy1, winc1, acc1, out1, busy2, winc2, acc2, out2} !== 32'b0) begin
      bad++; $display("FAIL reset_d1d2 got=%h want=0", {busy1, winc1, acc1, out1, busy2, winc2, acc2, out2});
    end
  endtask

  task automatic test_single();
    step();
    data[2*16 +: 16] = 16'hBEEF;
    req0 = 4'b0100;
    push_frame(0, 8'h02, 32'h0000BEEF, 2);
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if ({busy0, winc0, acc0, out0} !== {1'b1, 1'b0, 4'b0100, 8'h00}) begin
      bad++; $display("FAIL single_rel got=%b acc=%b want acc=0100", {busy0, winc0, out0}, acc0);
    end
    step();
    req0 = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({busy0, acc0} !== 5'b0) begin
      bad++; $display("FAIL single_release busy=%b acc=%b want 0", busy0, acc0);
    end
  endtask

  task automatic test_fixed_prio();
    step();
    data[1*16 +: 16] = 16'h1122;
    data[3*16 +: 16] = 16'h3344;
    req0 = 4'b1010;
    push_frame(0, 8'h01, 32'h00001122, 2);
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if (acc0 !== 4'b0010) begin bad++; $display("FAIL prio_first acc=%b want=0010", acc0); end
    step();
    req0 = 4'b1000;
    push_frame(0, 8'h03, 32'h00003344, 2);
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if (acc0 !== 4'b1000) begin bad++; $display("FAIL prio_second acc=%b want=1000", acc0); end
    step();
    req0 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    int g;
    step();
    for (int c = 0; c < 4; c++) data[c*16 +: 16] = 16'hA0A1 + 16'(16'h1010 * c);
    req1 = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      push_frame(1, 8'(g), 32'(16'hA0A1 + 16'(16'h1010 * g)), 2);
      wait_until(1, 0, 40);
      @(negedge clk);
      want = 4'b0001 << g;
      total++;
      if (acc1 !== want) begin bad++; $display("FAIL rr_grant%0d acc=%b want=%b", n, acc1, want); end
      step();
      req1[g] = 1'b0;
      step();
      req1 = 4'b1111;
    end
    req1 = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_backpressure();
    step();
    data[15:0] = 16'h1234;
    req0 = 4'b0001;
    push_frame(0, 8'h00, 32'h00001234, 2);
    wait_until(0, 2, 40);
    #1 wfull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (winc0 !== 1'b0 || out0 !== 8'h12) begin
        bad++; $display("FAIL bp_hold%0d winc=%b out=%h want winc=0 out=12", i, winc0, out0);
      end
      @(posedge clk);
    end
    #1 wfull = 1'b0;
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if (acc0 !== 4'b0001) begin bad++; $display("FAIL bp_rel acc=%b want=0001", acc0); end
    step();
    req0 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    step();
    data[15:0] = 16'hA55A;
    req0 = 4'b0001;
    qpush(0, 8'h00);              // only the header goes out before reset
    wait_until(0, 0, 40);
    #1;
    wfull = 1'b1;
    rst   = 1'b1;
    req0  = 4'b0000;
    @(negedge clk);
    step();
    rst   = 1'b0;
    wfull = 1'b0;
    @(negedge clk);
    total++;
    if ({busy0, winc0, acc0, out0} !== 14'b0) begin
      bad++; $display("FAIL rst_mid got=%b want=0", {busy0, winc0, acc0, out0});
    end
    step();
    data[15:0] = 16'h5AA5;
    req0 = 4'b0001;
    push_frame(0, 8'h00, 32'h00005AA5, 2);
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if (acc0 !== 4'b0001) begin bad++; $display("FAIL rst_newframe acc=%b want=0001", acc0); end
    step();
    req0 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wide();
    step();
    data2[7*32 +: 32] = 32'h01020304;
    req2 = 8'h80;
    push_frame(2, 8'h07, 32'h01020304, 4);
    wait_until(2, 0, 60);
    @(negedge clk);
    total++;
    if (acc2 !== 8'h80) begin bad++; $display("FAIL wide_acc acc=%h want=80", acc2); end
    step();
    req2 = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if (busy2 !== 1'b0) begin bad++; $display("FAIL wide_idle busy=%b want=0", busy2); end
  endtask

  task automatic test_drop_req();
    step();
    data[1*16 +: 16] = 16'hCAFE;
    req0 = 4'b0010;
    push_frame(0, 8'h01, 32'h0000CAFE, 2);
    wait_until(0, 2, 40);
    #1 req0 = 4'b0000;
    wait_until(0, 0, 40);
    @(negedge clk);
    total++;
    if (busy0 !== 1'b1 || acc0 !== 4'b0010) begin
      bad++; $display("FAIL drop_rel busy=%b acc=%b want busy=1 acc=0010", busy0, acc0);
    end
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0 || acc0 !== 4'b0000) begin
      bad++; $display("FAIL drop_exit busy=%b acc=%b want 0", busy0, acc0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_prio();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_wide();
    test_drop_req();
    repeat (3) @(negedge clk);
    total++;
    if (exp0.size() + exp1.size() + exp2.size() != 0) begin
      bad++; $display("FAIL leftover got=%0d want=0", exp0.size() + exp1.size() + exp2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
